// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner sequencer for a shared 4:1 mux channel.
// Per-grant burst limit, valid/ready handshake on the shared output.
module mux4_rr_arbiter #(
  parameter int WIDTH = 1,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] y,
  output logic             out_vld,
  output logic             s1,
  output logic             s0,
  output logic [3:0]       gnt,
  output logic             busy
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    sel;
  logic [1:0]    sel_nxt;
  logic [1:0]    ptr;
  logic [1:0]    ptr_nxt;
  logic [3:0]    gnt_nxt;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_nxt;

  logic       xfer;
  logic       rel;
  logic [1:0] base;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] win;
  logic       found;

  assign busy    = (state == GRANT);
  assign out_vld = busy && req[sel];
  assign xfer    = out_vld && out_rdy;
  assign s1      = sel[1];
  assign s0      = sel[0];

  always_comb begin
    y = a;
    unique case (sel)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
    endcase
  end

  // Owner drops its request, or the last beat of the burst transfers.
  assign rel = busy && (!req[sel] || (xfer && beat_cnt == LAST));

  // On release the search starts just past the old owner.
  assign base = busy ? sel + 2'd1 : ptr;

  always_comb begin
    rot = req;
    unique case (base)
      2'd0: rot = req;
      2'd1: rot = {req[0], req[3:1]};
      2'd2: rot = {req[1:0], req[3:2]};
      2'd3: rot = {req[2:0], req[3]};
    endcase
  end

  always_comb begin
    off = 2'd0;
    if (rot[0])
      off = 2'd0;
    else if (rot[1])
      off = 2'd1;
    else if (rot[2])
      off = 2'd2;
    else
      off = 2'd3;
  end

  assign found = |rot;
  assign win   = base + off;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    beat_nxt  = beat_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = win;
          gnt_nxt   = 4'b0001 << win;
          beat_nxt  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nxt = sel + 2'd1;
          if (found) begin
            sel_nxt  = win;
            gnt_nxt  = 4'b0001 << win;
            beat_nxt = '0;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
          end
        end else if (xfer) begin
          beat_nxt = beat_cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'd0;
      ptr      <= 2'd0;
      gnt      <= 4'b0000;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      beat_cnt <= beat_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: three instances (BURST 1,4,2) driven in
// parallel and compared each cycle against an owner/turn model.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       a, b, c, d;
  logic       out_rdy;

  logic       y [3];
  logic       out_vld [3];
  logic       s1 [3];
  logic       s0 [3];
  logic       busy [3];
  logic [3:0] gnt [3];

  int errors = 0;
  int checks = 0;

  int bl   [3];
  int own  [3];
  int msel [3];
  int mptr [3];
  int mcnt [3];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(1), .BURST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d), .out_rdy(out_rdy),
    .y(y[0]), .out_vld(out_vld[0]), .s1(s1[0]), .s0(s0[0]),
    .gnt(gnt[0]), .busy(busy[0])
  );

  mux4_rr_arbiter #(.WIDTH(1), .BURST(4)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d), .out_rdy(out_rdy),
    .y(y[1]), .out_vld(out_vld[1]), .s1(s1[1]), .s0(s0[1]),
    .gnt(gnt[1]), .busy(busy[1])
  );

  mux4_rr_arbiter #(.WIDTH(1), .BURST(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d), .out_rdy(out_rdy),
    .y(y[2]), .out_vld(out_vld[2]), .s1(s1[2]), .s0(s0[2]),
    .gnt(gnt[2]), .busy(busy[2])
  );

  function automatic int first_from(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      own[i] = -1;
      msel[i] = 0;
      mptr[i] = 0;
      mcnt[i] = 0;
    end
  endtask

  // Owner/turn bookkeeping from the arbitration rules, applied per edge.
  task automatic model_edge();
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (own[i] < 0) begin
        w = first_from(req, mptr[i]);
        if (w >= 0) begin
          own[i] = w;
          msel[i] = w;
          mcnt[i] = 0;
        end
      end else if (!req[own[i]] || (out_rdy && mcnt[i] == bl[i] - 1)) begin
        mptr[i] = (own[i] + 1) % 4;
        w = first_from(req, mptr[i]);
        if (w >= 0) begin
          own[i] = w;
          msel[i] = w;
          mcnt[i] = 0;
        end else begin
          own[i] = -1;
        end
      end else if (out_rdy) begin
        mcnt[i] = mcnt[i] + 1;
      end
    end
  endtask

  function automatic logic [8:0] exp_vec(int i);
    logic [3:0] dv;
    logic [3:0] g;
    logic       v;
    dv = {d, c, b, a};
    g = (own[i] < 0) ? 4'b0000 : 4'(1 << own[i]);
    v = (own[i] >= 0) && req[msel[i]];
    return {g, 2'(msel[i]), own[i] >= 0, v, dv[msel[i]]};
  endfunction

  function automatic logic [8:0] act_vec(int i);
    return {gnt[i], s1[i], s0[i], busy[i], out_vld[i], y[i]};
  endfunction

  task automatic tick();
    {a, b, c, d} = 4'($urandom);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'h0;
    out_rdy = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'hF;
    out_rdy = 1'b1;
    model_reset();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gnt[i] !== 4'b0000 || out_vld[i] !== 1'b0 ||
          {s1[i], s0[i]} !== 2'b00 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset u%0d: gnt=%b vld=%b sel=%b%b busy=%b want 0000 0 00 0",
                 i, gnt[i], out_vld[i], s1[i], s0[i], busy[i]);
      end
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gnt[i] !== 4'b0001) begin
        errors++;
        $display("FAIL reset_release u%0d: gnt=%b want 0001", i, gnt[i]);
      end
      checks++;
      if (act_vec(i) !== exp_vec(i)) begin
        errors++;
        $display("FAIL reset_model u%0d: got=%b want=%b", i, act_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'hF;
    out_rdy = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (gnt[0] !== seq[n]) begin
        errors++;
        $display("FAIL rotation step%0d: gnt=%b want %b", n, gnt[0], seq[n]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL rotation_model u%0d step%0d: got=%b want=%b",
                   i, n, act_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_burst_limit();
    logic [3:0] want;
    do_reset();
    req = 4'b0101;
    out_rdy = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      want = ((n / 4) % 2 == 0) ? 4'b0001 : 4'b0100;
      checks++;
      if (gnt[1] !== want || out_vld[1] !== 1'b1) begin
        errors++;
        $display("FAIL burst_limit step%0d: gnt=%b vld=%b want %b 1",
                 n, gnt[1], out_vld[1], want);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL burst_model u%0d step%0d: got=%b want=%b",
                   i, n, act_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_stall_drop();
    do_reset();
    req = 4'b0110;
    out_rdy = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'b0110;
    for (int n = 0; n < 5; n++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (gnt[i] !== 4'b0010 || act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL stall u%0d step%0d: got=%b want=%b (gnt 0010)",
                   i, n, act_vec(i), exp_vec(i));
        end
      end
    end
    // Out of stall: the 4-beat instance must still owe a full burst.
    out_rdy = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (gnt[1] !== 4'b0010) begin
        errors++;
        $display("FAIL stall_beats step%0d: gnt=%b want 0010", n, gnt[1]);
      end
    end
    do_reset();
    req = 4'b0010;
    tick();
    out_rdy = 1'b0;
    tick();
    req = 4'b0100;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gnt[i] !== 4'b0100 || act_vec(i) !== exp_vec(i)) begin
        errors++;
        $display("FAIL drop_to_c u%0d: got=%b want=%b (gnt 0100)",
                 i, act_vec(i), exp_vec(i));
      end
    end
    req = 4'b0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gnt[i] !== 4'b0000 || busy[i] !== 1'b0 ||
          {s1[i], s0[i]} !== 2'b10 || act_vec(i) !== exp_vec(i)) begin
        errors++;
        $display("FAIL drop_idle u%0d: got=%b want=%b (gnt 0000 sel 10)",
                 i, act_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_sole_requester();
    do_reset();
    req = 4'b1000;
    out_rdy = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (gnt[2] !== 4'b1000 || out_vld[2] !== 1'b1 || {s1[2], s0[2]} !== 2'b11) begin
        errors++;
        $display("FAIL sole step%0d: gnt=%b vld=%b want 1000 1", n, gnt[2], out_vld[2]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL sole_model u%0d step%0d: got=%b want=%b",
                   i, n, act_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1000;
    out_rdy = 1'b1;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gnt[i] !== 4'b0000 || out_vld[i] !== 1'b0 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset u%0d: gnt=%b vld=%b want 0000 0",
                 i, gnt[i], out_vld[i]);
      end
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    req = 4'hF;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gnt[i] !== 4'b0001 || act_vec(i) !== exp_vec(i)) begin
        errors++;
        $display("FAIL async_restart u%0d: got=%b want=%b (gnt 0001)",
                 i, act_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random u%0d cyc%0d: got=%b want=%b",
                   i, n, act_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    bl[0] = 1;
    bl[1] = 4;
    bl[2] = 2;
    rst_n = 1'b0;
    req = 4'h0;
    out_rdy = 1'b0;
    {a, b, c, d} = 4'h0;
    model_reset();
    test_reset();
    test_rotation();
    test_burst_limit();
    test_stall_drop();
    test_sole_requester();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
